seq_detect_param: RTL
=====================

Name: seq_detect_param

Overview:
Parametrised successor to the fixed 2-bit D-flip-flop state machines used in the sequential-circuit projects. It detects a PAT_W-bit serial pattern on input x, with selectable overlapping or non-overlapping detection. The pattern can be reloaded at run time. It exposes the detection flag F, a progress state S and a saturating match counter. It sits directly on a serial bit stream, clocked by the project clock.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, pattern loaded on reset; MSB is compared against the oldest bit.
OVERLAP, 1, 1 = matches may share bits; 0 = history restarts after each match.
CNT_W, 8, width of the match counter.

Ports:
CLK  input  1  single clock; all state changes on its rising edge.
RESET  input  1  asynchronous, active-high reset.
x  input  1  serial data bit, sampled when en=1.
en  input  1  sample enable; when 0, x is ignored.
pat_load  input  1  load pat_in as the new pattern.
pat_in  input  PAT_W  new pattern value.
clr_cnt  input  1  synchronous clear of match_count.
F  output  1  registered one-cycle match pulse.
S  output  SW=$clog2(PAT_W+1)  valid history bits held, saturating at PAT_W.
match_count  output  CNT_W  number of matches, saturating at all-ones.

Behaviour:
- Reset state (asynchronous): pat_reg=PATTERN, hist=0, S=0, F=0, match_count=0.
- Internal registers:
  - hist[PAT_W-1:0] is the bit history; newest bit at bit 0.
  - pat_reg holds the active pattern.
- Rising edge with pat_load=1 (highest priority after RESET):
  - pat_reg<=pat_in; hist<=0; S<=0; F<=0.
  - The en/x sample in that cycle is dropped.
  - match_count is unaffected unless clr_cnt=1.
- Rising edge with en=1 and pat_load=0:
  - nh = {hist[PAT_W-2:0], x}.
  - match = (nh==pat_reg) && (S>=PAT_W-1).
  - hist<=nh; F<=match.
  - If match and OVERLAP=0: S<=0.
  - Otherwise: S<=min(S+1, PAT_W).
- Rising edge with en=0 and pat_load=0: hist and S hold; F<=0.
- Latency: F rises in the cycle after the edge that samples the completing bit, and stays high exactly 1 cycle per match.
- Consecutive matches:
  - OVERLAP=1: back-to-back F pulses are possible, e.g. pattern 1111 with x held at 1.
  - OVERLAP=0: a new match needs at least PAT_W fresh samples.
- match_count:
  - On match: +1, holding at 2^CNT_W-1.
  - clr_cnt=1 takes priority: count<=0 even if a match occurs in the same cycle. F still pulses.
- RESET asserted mid-stream: all state clears immediately, with no clock needed. The first match after reset requires PAT_W new samples.
- S never exceeds PAT_W; hist bits older than PAT_W are discarded.
- Outputs are registers only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package seq_pkg:
  - function sw_of(PAT_W) = $clog2(PAT_W+1).
  - Constant DEFAULT_PATTERN_4 = 4'b1011.
  - Enum det_mode_e {NON_OVERLAP=0, OVERLAP=1} for the OVERLAP parameter.
- One sub-module: sat_counter, holding the CNT_W saturating counter with inc and priority clr inputs.
- History, match logic and S stay in the top module.

Test Plan:
1. Defaults (1011, OVERLAP=1), en=1, stream x=1,0,1,1,0,1,1 -> F high in the cycle after samples 4 and 7; match_count=2; S=1,2,3,4,4,4,4.
2. OVERLAP=0, same stream -> F only after sample 4; S=1,2,3,0,1,2,3; match_count=1.
3. Stream 1,0 with en=1, then en=0 for 3 cycles, then 1,1 -> S holds at 2 during the gap; F pulses after the final 1; the ignored x values have no effect.
4. After 3 valid samples, pat_load=1 with pat_in=4'b0000 and en=1 in the same cycle -> S=0, F=0, sample dropped; then four zeros -> F after the 4th.
5. match_count preset near saturation (CNT_W=2; 3 matches, then a 4th) -> count holds at 3. Then clr_cnt=1 in a match cycle -> count=0 and F=1.
6. Assert RESET asynchronously between clock edges mid-pattern -> F, S and match_count read 0 before the next edge; pat_reg returns to 1011.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_pkg;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } det_mode_e;

    localparam logic [3:0] DEFAULT_PATTERN_4 = 4'b1011;

    // Width needed to count 0..pat_w valid history bits.
    function automatic int sw_of(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        // NOTE: defaulting every combinational output first keeps this block latch-free.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial PAT_W-bit pattern detector with run-time pattern reload,
// selectable overlapping detection and a saturating match counter.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN_4),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      x,
    input  logic                      en,
    input  logic                      pat_load,
    input  logic [PAT_W-1:0]          pat_in,
    input  logic                      clr_cnt,
    output logic                      F,
    output logic [sw_of(PAT_W)-1:0]   S,
    output logic [CNT_W-1:0]          match_count
);

    localparam int             SW     = sw_of(PAT_W);
    localparam det_mode_e      MODE   = (OVERLAP != 0) ? seq_pkg::OVERLAP : NON_OVERLAP;
    localparam logic [SW-1:0]  S_MAX  = SW'(PAT_W);
    localparam logic [SW-1:0]  S_THR  = SW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_d,  pat_q;
    logic [PAT_W-1:0] hist_d, hist_q;
    logic [SW-1:0]    s_d,    s_q;
    logic             f_d,    f_q;
    logic [PAT_W-1:0] nh;
    logic             match;

    assign nh = {hist_q[PAT_W-2:0], x};

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        s_d    = s_q;
        f_d    = 1'b0;
        match  = 1'b0;
        if (pat_load) begin
            // A reload restarts the history; the sample in this cycle is discarded.
            pat_d  = pat_in;
            hist_d = '0;
            s_d    = '0;
        end else if (en) begin
            match  = (nh == pat_q) && (s_q >= S_THR);
            hist_d = nh;
            f_d    = match;
            if (match && (MODE == NON_OVERLAP)) begin
                s_d = '0;
            end else if (s_q != S_MAX) begin
                s_d = s_q + SW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            s_q    <= '0;
            f_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            s_q    <= s_d;
            f_q    <= f_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (CLK),
        .rst  (RESET),
        .inc  (match),
        .clr  (clr_cnt),
        .count(match_count)
    );

    assign F = f_q;
    assign S = s_q;

endmodule
